// File: rtl/dice_pkg.sv
// Shared types and helpers for the dice roll controller: FSM states,
// default die/bus sizes, and the sample-width calculation.
package dice_pkg;

  localparam int MAX_SIDES_DEF = 20;
  localparam int SW_DEF        = $clog2(MAX_SIDES_DEF + 1);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CHECK,
    DONE
  } state_t;

  // Smallest n with 2**n >= sides; callers only pass legal sides (>= 2).
  function automatic int bits_for_sides(input int sides);
    int n;
    n = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < sides) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/dice_roll_ctrl.sv
// Requests just enough RNG bits for one die sample and uses rejection
// sampling to return a uniform value in 1..sides, with bounded retries and RNG wait.
module dice_roll_ctrl
  import dice_pkg::*;
#(
  parameter int MAX_SIDES   = MAX_SIDES_DEF,
  parameter int SW          = SW_DEF,
  parameter int RETRY_LIMIT = 8,
  parameter int RNG_TIMEOUT = 64
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          roll_req_i,
  input  logic [SW-1:0] sides_i,
  output logic          busy_o,
  output logic          rng_start_o,
  input  logic          rng_result_i,
  input  logic          rng_done_i,
  output logic [SW-1:0] value_o,
  output logic          valid_o,
  output logic          err_o
);

  localparam int NBW = $clog2(SW + 1);
  localparam int RW  = $clog2(RETRY_LIMIT + 1);
  localparam int TW  = $clog2(RNG_TIMEOUT + 1);

  state_t          state_q, state_d;
  logic [SW-1:0]   sidesLat_q, sidesLat_d;
  logic [NBW-1:0]  nBits_q, nBits_d;
  logic [SW-1:0]   sample_q, sample_d;
  logic [NBW-1:0]  bitCnt_q, bitCnt_d;
  logic [RW-1:0]   retryCnt_q, retryCnt_d;
  logic [TW-1:0]   toCnt_q, toCnt_d;
  logic [SW-1:0]   value_q, value_d;
  logic            err_q, err_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            rngStart_q, rngStart_d;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q    <= IDLE;
      sidesLat_q <= '0;
      nBits_q    <= '0;
      sample_q   <= '0;
      bitCnt_q   <= '0;
      retryCnt_q <= '0;
      toCnt_q    <= '0;
      value_q    <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      rngStart_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sidesLat_q <= sidesLat_d;
      nBits_q    <= nBits_d;
      sample_q   <= sample_d;
      bitCnt_q   <= bitCnt_d;
      retryCnt_q <= retryCnt_d;
      toCnt_q    <= toCnt_d;
      value_q    <= value_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      rngStart_q <= rngStart_d;
    end
  end

  // Outputs are computed from the next state so they are registered yet
  // line up with the state they describe (valid during DONE, start during REQ).
  always_comb begin
    state_d    = state_q;
    sidesLat_d = sidesLat_q;
    nBits_d    = nBits_q;
    sample_d   = sample_q;
    bitCnt_d   = bitCnt_q;
    retryCnt_d = retryCnt_q;
    toCnt_d    = toCnt_q;
    value_d    = value_q;
    err_d      = err_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (roll_req_i) begin
          if (sides_i >= SW'(2) && sides_i <= SW'(MAX_SIDES)) begin
            sidesLat_d = sides_i;
            nBits_d    = NBW'(bits_for_sides(int'(sides_i)));
            sample_d   = '0;
            bitCnt_d   = '0;
            retryCnt_d = '0;
            state_d    = REQ;
          end else begin
            valid_d = 1'b1;
            err_d   = 1'b1;
            value_d = '0;
          end
        end
      end
      REQ: begin
        toCnt_d = '0;
        state_d = WAIT;
      end
      WAIT: begin
        if (rng_done_i) begin
          sample_d = {sample_q[SW-2:0], rng_result_i};
          bitCnt_d = bitCnt_q + NBW'(1);
          state_d  = ((bitCnt_q + NBW'(1)) == nBits_q) ? CHECK : REQ;
        end else if (toCnt_q == TW'(RNG_TIMEOUT - 1)) begin
          state_d = DONE;
          valid_d = 1'b1;
          err_d   = 1'b1;
          value_d = '0;
        end else begin
          toCnt_d = toCnt_q + TW'(1);
        end
      end
      CHECK: begin
        if (sample_q < sidesLat_q) begin
          state_d = DONE;
          valid_d = 1'b1;
          err_d   = 1'b0;
          value_d = sample_q + SW'(1);
        end else if (retryCnt_q == RW'(RETRY_LIMIT - 1)) begin
          state_d = DONE;
          valid_d = 1'b1;
          err_d   = 1'b1;
          value_d = '0;
        end else begin
          retryCnt_d = retryCnt_q + RW'(1);
          sample_d   = '0;
          bitCnt_d   = '0;
          state_d    = REQ;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d     = (state_d != IDLE);
    rngStart_d = (state_d == REQ);
  end

  assign busy_o      = busy_q;
  assign rng_start_o = rngStart_q;
  assign value_o     = value_q;
  assign valid_o     = valid_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_dice_roll_ctrl.sv
// Directed bench for dice_roll_ctrl: a scripted one-cycle-latency RNG stub
// and hand-computed expectations for each roll scenario.
module tb_dice_roll_ctrl;

  localparam int SW = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          roll_req;
  logic [SW-1:0] sides;
  logic          busy;
  logic          rng_start;
  logic          rng_result;
  logic          rng_done;
  logic [SW-1:0] value;
  logic          valid;
  logic          err;

  int testsRun  = 0;
  int failCount = 0;

  // Stub controls and observation counters
  bit stubSilent  = 1'b0;
  bit stubDefault = 1'b0;
  bit bitQ[$];
  int startCnt = 0;
  int validCnt = 0;

  dice_roll_ctrl dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .roll_req_i  (roll_req),
    .sides_i     (sides),
    .busy_o      (busy),
    .rng_start_o (rng_start),
    .rng_result_i(rng_result),
    .rng_done_i  (rng_done),
    .value_o     (value),
    .valid_o     (valid),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // RNG stub: answers each start pulse one cycle later with a scripted bit
  initial begin
    rng_done   = 1'b0;
    rng_result = 1'b0;
  end
  always @(posedge clk) begin
    rng_done <= 1'b0;
    if (rng_start && !stubSilent) begin
      rng_done <= 1'b1;
      if (bitQ.size() > 0) rng_result <= bitQ.pop_front();
      else                 rng_result <= stubDefault;
    end
  end

  always @(posedge clk) begin
    if (rng_start) startCnt <= startCnt + 1;
    if (valid)     validCnt <= validCnt + 1;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Presents one roll request for a single clock; returns at the next negedge
  task automatic applyStimulus(input int s);
    @(negedge clk);
    roll_req = 1'b1;
    sides    = SW'(s);
    @(negedge clk);
    roll_req = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int maxCycles);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxCycles; i++) begin
      if (valid) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  int startBase;
  int validBase;

  initial begin
    reset    = 1'b1;
    roll_req = 1'b0;
    sides    = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_start", int'(rng_start), 0);
    checkOutput("rst_value", int'(value), 0);
    checkOutput("rst_valid", int'(valid), 0);
    checkOutput("rst_err", int'(err), 0);
    reset = 1'b0;
    @(negedge clk);

    // sides=6, bits 1,0,1 -> sample 5 accepted -> value 6
    bitQ = '{1'b1, 1'b0, 1'b1};
    startBase = startCnt;
    applyStimulus(6);
    checkOutput("t1_busy_after_accept", int'(busy), 1);
    waitValid("t1", 200);
    checkOutput("t1_value", int'(value), 6);
    checkOutput("t1_err", int'(err), 0);
    checkOutput("t1_starts", startCnt - startBase, 3);
    @(negedge clk);
    checkOutput("t1_valid_one_cycle", int'(valid), 0);
    checkOutput("t1_busy_after", int'(busy), 0);
    checkOutput("t1_value_held", int'(value), 6);

    // sides=6, first sample 7 rejected, second sample 2 -> value 3
    bitQ = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    startBase = startCnt;
    applyStimulus(6);
    waitValid("t2", 200);
    checkOutput("t2_value", int'(value), 3);
    checkOutput("t2_err", int'(err), 0);
    checkOutput("t2_starts", startCnt - startBase, 6);
    @(negedge clk);

    // Reset during WAIT of a sides=20 roll aborts silently
    stubSilent = 1'b1;
    validBase  = validCnt;
    applyStimulus(20);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_rst_busy", int'(busy), 0);
    checkOutput("t6_rst_start", int'(rng_start), 0);
    checkOutput("t6_rst_value", int'(value), 0);
    checkOutput("t6_rst_valid", int'(valid), 0);
    checkOutput("t6_rst_err", int'(err), 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    checkOutput("t6_no_valid", validCnt - validBase, 0);
    checkOutput("t6_idle_busy", int'(busy), 0);
    stubSilent = 1'b0;
    bitQ = '{1'b1};
    applyStimulus(2);
    waitValid("t6b", 50);
    checkOutput("t6b_value", int'(value), 2);
    checkOutput("t6b_err", int'(err), 0);
    @(negedge clk);

    // Illegal sides 1 and 21: immediate error, no RNG traffic
    startBase = startCnt;
    applyStimulus(1);
    checkOutput("t3a_valid", int'(valid), 1);
    checkOutput("t3a_err", int'(err), 1);
    checkOutput("t3a_value", int'(value), 0);
    checkOutput("t3a_busy", int'(busy), 0);
    @(negedge clk);
    checkOutput("t3a_valid_drop", int'(valid), 0);
    applyStimulus(21);
    checkOutput("t3b_valid", int'(valid), 1);
    checkOutput("t3b_err", int'(err), 1);
    checkOutput("t3b_value", int'(value), 0);
    checkOutput("t3_starts", startCnt - startBase, 0);
    @(negedge clk);

    // sides=5 with RNG stuck at 1: eight rejected samples of 7
    stubDefault = 1'b1;
    bitQ.delete();
    startBase = startCnt;
    applyStimulus(5);
    waitValid("t4", 400);
    checkOutput("t4_err", int'(err), 1);
    checkOutput("t4_value", int'(value), 0);
    checkOutput("t4_starts", startCnt - startBase, 24);
    @(negedge clk);
    checkOutput("t4_busy_after", int'(busy), 0);
    stubDefault = 1'b0;

    // RNG never answers: timeout after 64 waiting cycles
    stubSilent = 1'b1;
    startBase  = startCnt;
    applyStimulus(6);
    repeat (60) @(negedge clk);
    checkOutput("t5_not_early", int'(valid), 0);
    waitValid("t5", 50);
    checkOutput("t5_err", int'(err), 1);
    checkOutput("t5_value", int'(value), 0);
    checkOutput("t5_starts", startCnt - startBase, 1);
    @(negedge clk);
    checkOutput("t5_busy_after", int'(busy), 0);
    stubSilent = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
